// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing helpers and pointer arithmetic for ring FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return clog2(depth + 1);
  endfunction

  // Pointer width: addresses 0..depth-1, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  // Advance a ring pointer by one, wrapping at depth-1 (depth need not be 2^n).
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : FIFO storage array, one synchronous write port and one read
//               port that is registered (FWFT=0) or asynchronous (FWFT=1).
//               The array itself has no reset so it maps onto RAM primitives.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write port; deliberately unreset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (FWFT == 0) begin : g_registered_read
      // Output register: only the read data register is reset/flushed, not the array.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          rd_data <= '0;
        end else if (rd_clr) begin
          rd_data <= '0;
        end else if (rd_en) begin
          rd_data <= mem[rd_addr];
        end
      end
    end else begin : g_async_read
      assign rd_data = mem[rd_addr];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sync_ring_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_ring_fifo
// Description : Single-clock circular-buffer FIFO with push/pop strobes,
//               registered status flags, occupancy, sticky error flags,
//               last-word pulses and optional first-word-fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ring_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_SIZE          = 16,
  parameter int DATA_WIDTH         = 32,
  parameter int ALMOST_FULL_LEVEL  = 12,
  parameter int ALMOST_EMPTY_LEVEL = 4,
  parameter int FWFT               = 0
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 enable,
  input  logic                                 clear,
  output logic                                 fifo_ready,
  input  logic                                 push,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 pop,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_valid,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 almost_full,
  output logic                                 almost_empty,
  output logic [count_width(FIFO_SIZE)-1:0]    data_count,
  output logic                                 overflow,
  output logic                                 underflow,
  output logic                                 pushed_last,
  output logic                                 popped_last
);

  localparam int COUNT_WIDTH = count_width(FIFO_SIZE);
  localparam int PTR_WIDTH   = ptr_width(FIFO_SIZE);

  logic [PTR_WIDTH-1:0]   write_ptr;
  logic [PTR_WIDTH-1:0]   read_ptr;
  logic [COUNT_WIDTH-1:0] next_count;
  logic                   active;
  logic                   flush;
  logic                   do_push;
  logic                   do_pop;

  assign fifo_ready = enable & ~clear;
  // Flush only takes effect while enabled: a disabled FIFO holds all state.
  assign flush      = enable & clear;

  // Accept decisions and next occupancy; a pop frees the slot a same-cycle push uses.
  always_comb begin
    active     = enable & ~clear;
    do_pop     = pop & active & ~empty;
    do_push    = push & active & (~full | do_pop);
    next_count = data_count;
    if (do_push && !do_pop) begin
      next_count = data_count + 1'b1;
    end else if (do_pop && !do_push) begin
      next_count = data_count - 1'b1;
    end
  end

  // Pointers, occupancy, registered flags, sticky errors and last-word pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_ptr    <= '0;
      read_ptr     <= '0;
      data_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      pushed_last  <= 1'b0;
      popped_last  <= 1'b0;
    end else if (flush) begin
      write_ptr    <= '0;
      read_ptr     <= '0;
      data_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      pushed_last  <= 1'b0;
      popped_last  <= 1'b0;
    end else begin
      if (do_push) begin
        write_ptr <= PTR_WIDTH'(ptr_next(32'(write_ptr), FIFO_SIZE));
      end
      if (do_pop) begin
        read_ptr <= PTR_WIDTH'(ptr_next(32'(read_ptr), FIFO_SIZE));
      end
      data_count   <= next_count;
      full         <= (next_count == COUNT_WIDTH'(FIFO_SIZE));
      empty        <= (next_count == '0);
      almost_full  <= (next_count >= COUNT_WIDTH'(ALMOST_FULL_LEVEL));
      almost_empty <= (next_count <= COUNT_WIDTH'(ALMOST_EMPTY_LEVEL));
      overflow     <= overflow  | (push & active & full & ~do_pop);
      underflow    <= underflow | (pop & active & empty);
      pushed_last  <= do_push & ~do_pop & (next_count == COUNT_WIDTH'(FIFO_SIZE));
      popped_last  <= do_pop & ~do_push & (next_count == '0);
    end
  end

  generate
    if (FWFT == 0) begin : g_registered_valid
      logic pop_valid;
      // One-cycle valid strobe aligned with the registered read data.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          pop_valid <= 1'b0;
        end else if (flush) begin
          pop_valid <= 1'b0;
        end else begin
          pop_valid <= do_pop;
        end
      end
      assign out_valid = pop_valid;
    end else begin : g_fwft_valid
      assign out_valid = ~empty;
    end
  endgenerate

  fifo_ram #(
    .DEPTH      (FIFO_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PTR_WIDTH),
    .FWFT       (FWFT)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (do_push),
    .wr_addr (write_ptr),
    .wr_data (in_data),
    .rd_en   (do_pop),
    .rd_clr  (flush),
    .rd_addr (read_ptr),
    .rd_data (out_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_sync_ring_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_ring_fifo
// Description : Scoreboard bench for sync_ring_fifo: queue-based reference
//               model, directed corner cases plus randomized traffic, and a
//               FWFT instance for fall-through timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_ring_fifo;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int AF = 4;
  localparam int AE = 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable, clear, push, pop;
  logic [DW-1:0] in_data;
  logic          fifo_ready, out_valid, full, empty, almost_full, almost_empty;
  logic          overflow, underflow, pushed_last, popped_last;
  logic [DW-1:0] out_data;
  logic [2:0]    data_count;

  logic          f_enable, f_clear, f_push, f_pop;
  logic [DW-1:0] f_in_data;
  logic          f_fifo_ready, f_out_valid, f_full, f_empty, f_almost_full, f_almost_empty;
  logic          f_overflow, f_underflow, f_pushed_last, f_popped_last;
  logic [DW-1:0] f_out_data;
  logic [2:0]    f_data_count;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  bit            m_ovf, m_udf, m_pl, m_el, m_valid;
  logic [DW-1:0] m_out;

  always #5 clock = ~clock;

  sync_ring_fifo #(
    .FIFO_SIZE(N), .DATA_WIDTH(DW), .ALMOST_FULL_LEVEL(AF),
    .ALMOST_EMPTY_LEVEL(AE), .FWFT(0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
    .fifo_ready(fifo_ready), .push(push), .in_data(in_data), .pop(pop),
    .out_data(out_data), .out_valid(out_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .data_count(data_count), .overflow(overflow), .underflow(underflow),
    .pushed_last(pushed_last), .popped_last(popped_last)
  );

  sync_ring_fifo #(
    .FIFO_SIZE(N), .DATA_WIDTH(DW), .ALMOST_FULL_LEVEL(AF),
    .ALMOST_EMPTY_LEVEL(AE), .FWFT(1)
  ) dut_fwft (
    .clock(clock), .reset_n(reset_n), .enable(f_enable), .clear(f_clear),
    .fifo_ready(f_fifo_ready), .push(f_push), .in_data(f_in_data), .pop(f_pop),
    .out_data(f_out_data), .out_valid(f_out_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty),
    .data_count(f_data_count), .overflow(f_overflow), .underflow(f_underflow),
    .pushed_last(f_pushed_last), .popped_last(f_popped_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare registered outputs with the model state after the last edge.
  task automatic check_state();
    int sz;
    sz = m_q.size();
    chk("data_count",   data_count,   sz);
    chk("full",         full,         sz == N);
    chk("empty",        empty,        sz == 0);
    chk("almost_full",  almost_full,  sz >= AF);
    chk("almost_empty", almost_empty, sz <= AE);
    chk("overflow",     overflow,     m_ovf);
    chk("underflow",    underflow,    m_udf);
    chk("pushed_last",  pushed_last,  m_pl);
    chk("popped_last",  popped_last,  m_el);
    chk("out_valid",    out_valid,    m_valid);
    chk("out_data",     out_data,     m_out);
  endtask

  // One cycle of stimulus; the model predicts what the coming edge does.
  task automatic step(input bit p, input bit q, input logic [DW-1:0] d, input bit en, input bit clr);
    int sz;
    bit dpop, dpush;
    @(negedge clock);
    check_state();
    push = p; pop = q; in_data = d; enable = en; clear = clr;
    #1 chk("fifo_ready", fifo_ready, en & ~clr);
    sz = m_q.size();
    m_pl = 0; m_el = 0; m_valid = 0;
    if (en && clr) begin
      m_q.delete();
      m_ovf = 0; m_udf = 0; m_out = '0;
    end else if (en) begin
      dpop  = q && (sz > 0);
      dpush = p && ((sz < N) || dpop);
      if (q && sz == 0) m_udf = 1;
      if (p && sz == N && !dpop) m_ovf = 1;
      if (dpop) begin
        m_out = m_q.pop_front();
        exp_q.push_back(m_out);
        m_valid = 1;
      end
      if (dpush) m_q.push_back(d);
      if (m_q.size() == N && sz != N) m_pl = 1;
      if (m_q.size() == 0 && sz != 0) m_el = 1;
    end
  endtask

  // Scoreboard monitor: every presented word must match the oldest expected pop.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (reset_n === 1'b1 && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("scoreboard_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    enable = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; in_data = '0;
    f_enable = 1'b1; f_clear = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_in_data = '0;
    m_ovf = 0; m_udf = 0; m_pl = 0; m_el = 0; m_valid = 0; m_out = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Fill to full, then one push too many
    for (int i = 1; i <= N; i++) step(1, 0, DW'(i), 1, 0);
    step(1, 0, 8'h66, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("fill_count_is_5", data_count, 5);

    // Drain in order, then one pop too many
    for (int i = 0; i < N; i++) step(0, 1, 8'h00, 1, 0);
    step(0, 1, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 1);

    // Wrap-around: push 3 / pop 3, four times
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) step(1, 0, DW'($urandom), 1, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 1, 0);
    end

    // Simultaneous push/pop on full and on empty
    for (int i = 0; i < N; i++) step(1, 0, DW'(8'h10 + i), 1, 0);
    step(1, 1, 8'hF0, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < N; i++) step(0, 1, 8'h00, 1, 0);
    step(1, 1, 8'hE1, 1, 0);
    step(0, 1, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);

    // Disabled FIFO ignores requests and raises no errors
    step(1, 1, 8'h77, 0, 0);
    step(0, 1, 8'h00, 0, 0);

    // Mid-stream clear with a push pending: the word is discarded
    for (int i = 0; i < 3; i++) step(1, 0, DW'($urandom), 1, 0);
    step(1, 1, 8'hCC, 1, 1);
    step(0, 0, 8'h00, 1, 0);

    // Asynchronous reset in the middle of a burst, right after a pop
    for (int i = 0; i < N + 1; i++) step(1, 0, DW'($urandom), 1, 0);
    step(0, 1, 8'h00, 1, 0);
    @(negedge clock);
    check_state();
    push = 0; pop = 0; clear = 0; enable = 1;
    reset_n = 1'b0;
    #1;
    chk("rst_count",     data_count, 0);
    chk("rst_empty",     empty, 1);
    chk("rst_aempty",    almost_empty, 1);
    chk("rst_full",      full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_overflow",  overflow, 0);
    m_q.delete(); exp_q.delete();
    m_ovf = 0; m_udf = 0; m_pl = 0; m_el = 0; m_valid = 0; m_out = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Randomized traffic with drifting push/pop bias
    for (int blk = 0; blk < 12; blk++) begin
      int bias;
      bias = $urandom_range(15, 85);
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 10,
             DW'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0);
      end
    end
    step(0, 0, 8'h00, 1, 0);
    @(negedge clock);
    check_state();
    chk("scoreboard_drained", exp_q.size(), 0);

    // First-word-fall-through timing
    chk("fwft_empty_init", f_empty, 1);
    chk("fwft_valid_init", f_out_valid, 0);
    f_push = 1; f_in_data = 8'hA5;
    @(negedge clock);
    f_in_data = 8'h3C;
    @(negedge clock);
    f_push = 0;
    chk("fwft_valid_before_pop", f_out_valid, 1);
    chk("fwft_data_before_pop",  f_out_data, 8'hA5);
    chk("fwft_count_2",          f_data_count, 2);
    f_pop = 1;
    @(negedge clock);
    chk("fwft_second_word", f_out_data, 8'h3C);
    chk("fwft_valid_second", f_out_valid, 1);
    @(negedge clock);
    f_pop = 0;
    chk("fwft_empty_after_pop", f_empty, 1);
    chk("fwft_valid_after_pop", f_out_valid, 0);
    chk("fwft_popped_last",     f_popped_last, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
